text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer.sv | 159 +++++++++++++++
 tb/tb_text_renderer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_renderer.sv
// Text-mode LCD renderer: character VRAM + font ROM to RGB565 through a 4-clock pixel pipeline.
// Defining TEXT_RENDERER_CURSOR_EN adds a blinking underline cursor.
module text_renderer #(
  parameter int          H_ACTIVE     = 480,
  parameter int          H_BLANK      = 51,
  parameter int          V_ACTIVE     = 272,
  parameter int          V_BLANK      = 20,
  parameter int          FONT_H       = 16,
  parameter logic [15:0] FG           = 16'hFFFF,
  parameter logic [15:0] BG           = 16'h0000,
  parameter int          BLINK_FRAMES = 32,
  localparam int         COLS         = H_ACTIVE / 8,
  localparam int         ROWS         = V_ACTIVE / FONT_H,
  localparam int         VA_W         = $clog2(COLS * ROWS),
  localparam int         FA_W         = 8 + $clog2(FONT_H)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [VA_W-1:0] v_adb,
  input  logic [7:0]      v_dout,
  output logic [FA_W-1:0] f_ad,
  input  logic [7:0]      f_dout,
  output logic            LCD_DE,
  output logic [4:0]      LCD_R,
  output logic [5:0]      LCD_G,
  output logic [4:0]      LCD_B,
  output logic            vsync,
  input  logic [4:0]      scroll_row,
  input  logic            cursor_on,
  input  logic [5:0]      cursor_col,
  input  logic [4:0]      cursor_row
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int FL_W    = $clog2(FONT_H);

  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic [4:0]      r_scroll;
  logic [VA_W-1:0] r_v_adb;
  logic [FA_W-1:0] r_f_ad;
  logic [3:0]      r_valid;
  logic [3:0]      r_cur;
  logic [3:0][2:0] r_x;
  logic [FL_W-1:0] r_line1;
  logic [FL_W-1:0] r_line2;

  logic            w_h_wrap;
  logic            w_active;
  logic            w_vsync;
  logic            w_cur;
  logic [VW-1:0]   w_scr_row;
  logic [FL_W-1:0] w_line;
  logic [HW-1:0]   w_col;
  logic [VW:0]     w_row_sum;
  logic [VW:0]     w_text_row;
  logic [VA_W-1:0] w_addr;
  logic            w_pix;
  logic            w_de;
  logic [15:0]     w_colour;

  assign w_h_wrap  = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_active  = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_vsync   = !rst && (r_h_cnt == '0) && (r_v_cnt == VW'(V_ACTIVE));
  assign w_scr_row = r_v_cnt >> FL_W;
  assign w_line    = r_v_cnt[FL_W-1:0];
  assign w_col     = r_h_cnt >> 3;

  // Both operands are below ROWS, so a single conditional subtract is a full modulo.
  assign w_row_sum  = {1'b0, w_scr_row} + (VW + 1)'(r_scroll);
  assign w_text_row = (w_row_sum >= (VW + 1)'(ROWS)) ? w_row_sum - (VW + 1)'(ROWS) : w_row_sum;
  assign w_addr     = VA_W'(w_text_row) * VA_W'(COLS) + VA_W'(w_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= (r_v_cnt == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  // Scroll is sampled only at frame start so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scroll <= '0;
    end else if (w_vsync) begin
      r_scroll <= 5'(int'(scroll_row) % ROWS);
    end
  end

`ifdef TEXT_RENDERER_CURSOR_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] r_frame_cnt;
  logic            r_blink_hide;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (w_vsync) begin
      if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt  <= '0;
        r_blink_hide <= ~r_blink_hide;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_cur = cursor_on && !r_blink_hide && (w_line >= FL_W'(FONT_H - 2)) &&
                 (32'(w_col) == 32'(cursor_col)) && (32'(w_scr_row) == 32'(cursor_row));
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_on, cursor_col, cursor_row};
  assign w_cur           = 1'b0;
`endif

  // Stage 1 drives VRAM, stage 3 drives the font ROM, stage 4 meets the glyph byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_cur   <= '0;
      r_x     <= '0;
      r_line1 <= '0;
      r_line2 <= '0;
      r_v_adb <= '0;
      r_f_ad  <= '0;
    end else begin
      r_valid <= {r_valid[2:0], w_active};
      r_cur   <= {r_cur[2:0], w_cur & w_active};
      r_x     <= {r_x[2:0], r_h_cnt[2:0]};
      r_line1 <= w_line;
      r_line2 <= r_line1;
      r_v_adb <= w_active ? w_addr : '0;
      r_f_ad  <= {v_dout, r_line2};
    end
  end

  always_comb begin
    w_pix    = f_dout[3'd7 - r_x[3]];
    w_colour = (w_pix ^ r_cur[3]) ? FG : BG;
    w_de     = r_valid[3] & ~rst;
  end

  assign v_adb                 = r_v_adb;
  assign f_ad                  = r_f_ad;
  assign vsync                 = w_vsync;
  assign LCD_DE                = w_de;
  assign {LCD_R, LCD_G, LCD_B} = w_de ? w_colour : 16'h0000;

endmodule

// File: tb/tb_text_renderer.sv
// Randomized self-checking bench for text_renderer against a cycle-index pixel model.
module tb_text_renderer;

  localparam int          H_ACTIVE     = 40;
  localparam int          H_BLANK      = 9;
  localparam int          V_ACTIVE     = 68;
  localparam int          V_BLANK      = 4;
  localparam int          FONT_H       = 4;
  localparam logic [15:0] FG           = 16'hA5C3;
  localparam logic [15:0] BG           = 16'h1E34;
  localparam int          BLINK_FRAMES = 2;
  localparam int          HT           = H_ACTIVE + H_BLANK;
  localparam int          VT           = V_ACTIVE + V_BLANK;
  localparam int          FT           = HT * VT;
  localparam int          COLS         = H_ACTIVE / 8;
  localparam int          ROWS         = V_ACTIVE / FONT_H;
  localparam int          VA_W         = $clog2(COLS * ROWS);
  localparam int          FA_W         = 8 + $clog2(FONT_H);
`ifdef TEXT_RENDERER_CURSOR_EN
  localparam bit          CUR_EN       = 1'b1;
`else
  localparam bit          CUR_EN       = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [VA_W-1:0] v_adb;
  logic [7:0]      v_dout;
  logic [FA_W-1:0] f_ad;
  logic [7:0]      f_dout;
  logic            LCD_DE;
  logic [4:0]      LCD_R;
  logic [5:0]      LCD_G;
  logic [4:0]      LCD_B;
  logic            vsync;
  logic [4:0]      scroll_row = 5'd0;
  logic            cursor_on  = 1'b0;
  logic [5:0]      cursor_col = 6'd0;
  logic [4:0]      cursor_row = 5'd0;

  logic [7:0]  vram [0:(1<<VA_W)-1];
  logic [7:0]  font [0:(1<<FA_W)-1];
  int          total = 0;
  int          bad = 0;
  int          m_cyc = 0;
  int          m_scroll = 0;
  int          m_nvs = 0;
  logic [16:0] pipe [4];

  always #5 clk = ~clk;

  text_renderer #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK),
    .FONT_H(FONT_H), .FG(FG), .BG(BG), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .v_adb(v_adb), .v_dout(v_dout), .f_ad(f_ad), .f_dout(f_dout),
    .LCD_DE(LCD_DE), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .vsync(vsync),
    .scroll_row(scroll_row), .cursor_on(cursor_on), .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  always @(posedge clk) begin
    v_dout <= vram[v_adb];
    f_dout <= font[f_ad];
  end

  // Pixel seen on screen for the cycle index cyc since reset release.
  function automatic logic [16:0] pix_model(int cyc, int scr, int nvs);
    int h, v, srow, line, col, trow;
    logic [7:0] code, bits;
    logic pix, cur;
    h = cyc % HT;
    v = (cyc / HT) % VT;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 17'h0;
    srow = v / FONT_H;
    line = v % FONT_H;
    col  = h / 8;
    trow = (srow + scr) % ROWS;
    code = vram[trow * COLS + col];
    bits = font[int'(code) * FONT_H + line];
    pix  = bits[7 - h % 8];
    cur  = CUR_EN && cursor_on && ((nvs / BLINK_FRAMES) % 2 == 0) && col == int'(cursor_col) &&
           srow == int'(cursor_row) && line >= FONT_H - 2;
    return {1'b1, (pix ^ cur) ? FG : BG};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc    <= 0;
      m_scroll <= 0;
      m_nvs    <= 0;
      pipe     <= '{default: 17'h0};
    end else begin
      pipe[0] <= pix_model(m_cyc, m_scroll, m_nvs);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
      if (m_cyc % FT == V_ACTIVE * HT) begin
        m_scroll <= int'(scroll_row) % ROWS;
        m_nvs    <= m_nvs + 1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pos(input int pos, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FT + 2; i++) begin
      @(negedge clk);
      if (m_cyc % FT == pos) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < (1 << VA_W); i++) vram[i] = 8'($urandom);
    for (int i = 0; i < (1 << FA_W); i++) font[i] = 8'($urandom);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if ({LCD_DE, LCD_R, LCD_G, LCD_B, vsync} !== 18'h0) begin
          bad++;
          $display("FAIL reset_out: got de=%b rgb=%h vs=%b want 0", LCD_DE,
                   {LCD_R, LCD_G, LCD_B}, vsync);
        end
      end
    end
    total++;
    if (v_adb !== '0) begin bad++; $display("FAIL reset_v_adb: got %h want 0", v_adb); end
    total++;
    if (f_ad !== '0) begin bad++; $display("FAIL reset_f_ad: got %h want 0", f_ad); end
  endtask

  task automatic test_glyph_a;
    logic [15:0] exp_px [8];
    logic [16:0] want;
    exp_px = '{BG, BG, BG, FG, FG, BG, BG, BG};
    for (int i = 0; i < (1 << VA_W); i++) vram[i] = 8'h41;
    font[8'h41 * FONT_H] = 8'h18;
    do_reset(10);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      want = (k < 4) ? 17'h0 : {1'b1, exp_px[k - 4]};
      total++;
      if ({LCD_DE, LCD_R, LCD_G, LCD_B} !== want) begin
        bad++;
        $display("FAIL glyph_a k=%0d: got %h want %h", k, {LCD_DE, LCD_R, LCD_G, LCD_B}, want);
      end
    end
  endtask

  task automatic test_frame_timing;
    int first_de = -1, de_total = 0, run = 0, max_run = 0, lines = 0;
    int vs_first = -1, vs_second = -1, vs_count = 0;
    logic prev_de = 1'b0;
    do_reset(10);
    for (int i = 0; i < 2 * FT + 8; i++) begin
      if (i > 0) @(negedge clk);
      if (LCD_DE && first_de < 0) first_de = i;
      if (i < FT + 4) begin
        if (LCD_DE) begin
          de_total++;
          run++;
          if (run > max_run) max_run = run;
          if (!prev_de) lines++;
        end else begin
          run = 0;
        end
      end
      prev_de = LCD_DE;
      if (vsync) begin
        vs_count++;
        if (vs_first < 0) vs_first = i;
        else if (vs_second < 0) vs_second = i;
      end
    end
    total++;
    if (first_de != 4) begin bad++; $display("FAIL first_de: got %0d want 4", first_de); end
    total++;
    if (de_total != H_ACTIVE * V_ACTIVE) begin
      bad++; $display("FAIL de_total: got %0d want %0d", de_total, H_ACTIVE * V_ACTIVE);
    end
    total++;
    if (max_run != H_ACTIVE) begin
      bad++; $display("FAIL de_run: got %0d want %0d", max_run, H_ACTIVE);
    end
    total++;
    if (lines != V_ACTIVE) begin bad++; $display("FAIL de_lines: got %0d want %0d", lines, V_ACTIVE); end
    total++;
    if (vs_first != V_ACTIVE * HT) begin
      bad++; $display("FAIL vsync_first: got %0d want %0d", vs_first, V_ACTIVE * HT);
    end
    total++;
    if (vs_second - vs_first != FT) begin
      bad++; $display("FAIL vsync_period: got %0d want %0d", vs_second - vs_first, FT);
    end
    total++;
    if (vs_count != 2) begin bad++; $display("FAIL vsync_count: got %0d want 2", vs_count); end
  endtask

  task automatic test_scroll;
    localparam int PRow2  = 2 * FONT_H * HT;
    localparam int PRow16 = 16 * FONT_H * HT;
    int  exp_adr [5];
    int  pos     [5];
    int  setv    [5];
    bit  ok;
    pos     = '{PRow2, 0, PRow2, 0, PRow16};
    setv    = '{3, -1, 20, -1, -1};
    exp_adr = '{2 * COLS, 3 * COLS, 5 * COLS, (20 % ROWS) * COLS,
                ((16 + 20 % ROWS) % ROWS) * COLS};
    scroll_row = 5'd0;
    do_reset(4);
    for (int s = 0; s < 5; s++) begin
      wait_pos(pos[s], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL scroll_wait s=%0d: got timeout want position", s); end
      if (setv[s] >= 0) scroll_row = 5'(setv[s]);
      @(negedge clk);
      total++;
      if (int'(v_adb) != exp_adr[s]) begin
        bad++; $display("FAIL scroll_adr s=%0d: got %0d want %0d", s, v_adb, exp_adr[s]);
      end
    end
  endtask

  task automatic test_cursor;
    int in_cell [4];
    int stray = 0;
    int c, h, v, f, want;
    in_cell = '{0, 0, 0, 0};
    for (int i = 0; i < (1 << VA_W); i++) vram[i] = 8'($urandom);
    for (int i = 0; i < (1 << FA_W); i++) font[i] = 8'h00;
    scroll_row = 5'd5;
    cursor_on  = 1'b1;
    cursor_col = 6'd1;
    cursor_row = 5'd2;
    do_reset(4);
    for (int i = 0; i < 4 * FT + 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 4 && LCD_DE && {LCD_R, LCD_G, LCD_B} == FG) begin
        c = (i - 4) % FT;
        f = (i - 4) / FT;
        h = c % HT;
        v = c / HT;
        if (h / 8 == 1 && v / FONT_H == 2 && v % FONT_H >= FONT_H - 2) in_cell[f]++;
        else stray++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      want = (CUR_EN && k < BLINK_FRAMES) ? 8 * 2 : 0;
      total++;
      if (in_cell[k] != want) begin
        bad++; $display("FAIL cursor_frame%0d: got %0d want %0d", k, in_cell[k], want);
      end
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL cursor_stray: got %0d want 0", stray); end
  endtask

  task automatic test_random_frames;
    logic [17:0] got, want;
    for (int i = 0; i < (1 << VA_W); i++) vram[i] = 8'($urandom);
    for (int i = 0; i < (1 << FA_W); i++) font[i] = 8'($urandom);
    cursor_on  = 1'b1;
    cursor_col = 6'($urandom_range(0, COLS - 1));
    cursor_row = 5'($urandom_range(0, ROWS - 1));
    scroll_row = 5'($urandom_range(0, 31));
    do_reset(3);
    for (int i = 0; i < 5 * FT; i++) begin
      @(negedge clk);
      got  = {LCD_DE, LCD_R, LCD_G, LCD_B, vsync};
      want = {(rst ? 17'h0 : pipe[3]), (!rst && (m_cyc % FT == V_ACTIVE * HT))};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random_px cyc=%0d: got %h want %h", m_cyc, got, want);
      end
      if (i % 700 == 350) scroll_row = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int vs_k = -1;
    wait_pos(30 * HT + 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_wait: got timeout want position"); end
    rst = 1'b1;
    #1;
    total++;
    if (LCD_DE !== 1'b0 || vsync !== 1'b0) begin
      bad++; $display("FAIL midrst_gate: got de=%b vs=%b want 0 0", LCD_DE, vsync);
    end
    @(negedge clk);
    total++;
    if (LCD_DE !== 1'b0 || v_adb !== '0) begin
      bad++; $display("FAIL midrst_clear: got de=%b adr=%h want 0 0", LCD_DE, v_adb);
    end
    rst = 1'b0;
    for (int k = 1; k <= FT + 2; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        total++;
        if (LCD_DE !== (k >= 4)) begin
          bad++; $display("FAIL midrst_de k=%0d: got %b want %b", k, LCD_DE, k >= 4);
        end
      end
      if (vsync && vs_k < 0) vs_k = k;
    end
    total++;
    if (vs_k != V_ACTIVE * HT) begin
      bad++; $display("FAIL midrst_vsync: got %0d want %0d", vs_k, V_ACTIVE * HT);
    end
  endtask

  initial begin
    test_reset();
    test_glyph_a();
    test_frame_timing();
    test_scroll();
    test_cursor();
    test_random_frames();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
